// File: rtl/seg7_to_hex_capture_if.sv
// Scan-bus sample inputs and decoded capture outputs of seg7_to_hex_capture.
// The bench or scan driver holds the master side; the capture block holds the slave side.
interface seg7_to_hex_capture_if #(
    parameter int DIGITS = 4,
    parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
);
    logic [6:0]          seg_n;
    logic [IW-1:0]       dig_idx;
    logic                seg_valid;
    logic                clear;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   digit_err;
    logic                commit;
    logic                frame_done;

    modport master (
        output seg_n, dig_idx, seg_valid, clear,
        input  value, digit_err, commit, frame_done
    );

    modport slave (
        input  seg_n, dig_idx, seg_valid, clear,
        output value, digit_err, commit, frame_done
    );
endinterface

// File: rtl/seg7_to_hex_capture.sv
// Filters scanned active-low 7-segment samples and commits the decoded hex
// nibble per digit once a run of STABLE_CNT identical samples is seen.
module seg7_to_hex_capture #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_to_hex_capture_if.slave  bus
);
    localparam int         IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW:0] DIG_LIM = (IW + 1)'(DIGITS);
    localparam logic [7:0] SC     = 8'(STABLE_CNT);
    localparam logic [7:0] SC_M1  = 8'(STABLE_CNT - 1);

    logic [IW-1:0]       r_cand_idx;
    logic [6:0]          r_cand_pat;
    logic [7:0]          r_cnt;
    logic [DIGITS-1:0]   r_seen;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_err;
    logic                r_commit;
    logic                r_frame;

    logic [6:0]          w_p;
    logic [3:0]          w_nib;
    logic                w_ok;
    logic                w_accept;
    logic                w_match;
    logic                w_fire;
    logic [7:0]          w_cnt_next;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_seen_next;

    assign w_p = ~bus.seg_n;

    always_comb begin
        w_ok  = 1'b1;
        w_nib = 4'h0;
        case (w_p)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h67: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h58: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: w_ok = 1'b0;
        endcase
    end

    assign w_accept   = bus.seg_valid && ({1'b0, bus.dig_idx} < DIG_LIM);
    assign w_match    = (bus.dig_idx == r_cand_idx) && (bus.seg_n == r_cand_pat) && (r_cnt != 8'd0);
    assign w_cnt_next = !w_match ? 8'd1 : (r_cnt >= SC) ? SC : 8'(r_cnt + 8'd1);
    // Fire only on the transition into saturation, so a held run commits once.
    assign w_fire     = w_accept && (w_match ? (r_cnt == SC_M1) : (SC == 8'd1));

    always_comb begin
        for (int k = 0; k < DIGITS; k++)
            w_onehot[k] = (bus.dig_idx == IW'(k));
    end
    assign w_seen_next = r_seen | w_onehot;

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            r_cand_idx <= '0;
            r_cand_pat <= '0;
            r_cnt      <= '0;
            r_seen     <= '0;
            r_value    <= '0;
            r_err      <= '0;
            r_commit   <= 1'b0;
            r_frame    <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            r_frame  <= 1'b0;
            if (w_accept) begin
                r_cand_idx <= bus.dig_idx;
                r_cand_pat <= bus.seg_n;
                r_cnt      <= w_cnt_next;
            end
            if (w_fire) begin
                r_commit <= 1'b1;
                for (int k = 0; k < DIGITS; k++) begin
                    if (w_onehot[k]) begin
                        if (w_ok) r_value[4*k +: 4] <= w_nib;
                        r_err[k] <= ~w_ok;
                    end
                end
                if (&w_seen_next) begin
                    r_frame <= 1'b1;
                    r_seen  <= '0;
                end else begin
                    r_seen  <= w_seen_next;
                end
            end
        end
    end

    assign bus.value      = r_value;
    assign bus.digit_err  = r_err;
    assign bus.commit     = r_commit;
    assign bus.frame_done = r_frame;
endmodule

// File: tb/tb_seg7_to_hex_capture.sv
// Directed bench for seg7_to_hex_capture: expected commits are queued as samples
// are driven and popped whenever the DUT pulses commit.
module tb_seg7_to_hex_capture;
    logic clk = 1'b0;
    logic reset;
    logic sel;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seg7_to_hex_capture_if #(.DIGITS(4)) b4 ();
    seg7_to_hex_capture_if #(.DIGITS(3)) b3 ();

    seg7_to_hex_capture #(.DIGITS(4), .STABLE_CNT(3)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    seg7_to_hex_capture #(.DIGITS(3), .STABLE_CNT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    logic [15:0] o_value;
    logic [3:0]  o_err;
    logic        o_commit, o_frame;
    assign o_value  = sel ? {4'h0, b3.value}     : b4.value;
    assign o_err    = sel ? {1'b0, b3.digit_err} : b4.digit_err;
    assign o_commit = sel ? b3.commit            : b4.commit;
    assign o_frame  = sel ? b3.frame_done        : b4.frame_done;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  err;
        logic        frame;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] e, input logic f);
        exp_t x;
        x.value = v; x.err = e; x.frame = f;
        q.push_back(x);
    endtask

    // One clock: drive a sample, let the edge take it, then score the result.
    task automatic smp(input int idx, input logic [6:0] p, input bit v = 1'b1,
                       input bit clr = 1'b0, input bit rst = 1'b0);
        exp_t e;
        b4.seg_n = ~p; b4.dig_idx = 2'(idx); b4.seg_valid = v && !sel; b4.clear = clr && !sel;
        b3.seg_n = ~p; b3.dig_idx = 2'(idx); b3.seg_valid = v && sel;  b3.clear = clr && sel;
        reset = rst;
        @(posedge clk);
        #1;
        b4.seg_valid = 1'b0; b4.clear = 1'b0;
        b3.seg_valid = 1'b0; b3.clear = 1'b0;
        reset = 1'b0;
        if (o_commit) begin
            if (q.size() == 0) begin
                chk("unexpected_commit", o_commit, 0);
            end else begin
                e = q.pop_front();
                chk("value", o_value, e.value);
                chk("digit_err", o_err, e.err);
                chk("frame_done", o_frame, e.frame);
            end
        end else begin
            chk("frame_idle", o_frame, 0);
            if (q.size() != 0) begin
                chk("missed_commit", o_commit, 1);
                void'(q.pop_front());
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_value"}, o_value, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_commit"}, o_commit, 0);
        chk({tag, "_frame"}, o_frame, 0);
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b1;
        b4.seg_n = 7'h7F; b4.dig_idx = '0; b4.seg_valid = 1'b0; b4.clear = 1'b0;
        b3.seg_n = 7'h7F; b3.dig_idx = '0; b3.seg_valid = 1'b0; b3.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_zero("reset");

        // First commit on digit 0.
        smp(0, 7'h06); smp(0, 7'h06);
        push(16'h0001, 4'h0, 1'b0); smp(0, 7'h06);

        smp(0, 7'h06, 1'b0, 1'b1);
        chk_zero("clear");

        // Full frame: frame_done only on the 4th digit.
        smp(0, 7'h06); smp(0, 7'h06); push(16'h0001, 4'h0, 1'b0); smp(0, 7'h06);
        smp(1, 7'h5B); smp(1, 7'h5B); push(16'h0021, 4'h0, 1'b0); smp(1, 7'h5B);
        smp(2, 7'h4F); smp(2, 7'h4F); push(16'h0321, 4'h0, 1'b0); smp(2, 7'h4F);
        smp(3, 7'h77); smp(3, 7'h77); push(16'hA321, 4'h0, 1'b1); smp(3, 7'h77);
        // seen must restart from empty after frame_done
        smp(0, 7'h06); smp(0, 7'h06); push(16'hA321, 4'h0, 1'b0); smp(0, 7'h06);

        // Glitch on digit 1 with gaps inside the final run.
        smp(1, 7'h7F); smp(1, 7'h7F); smp(1, 7'h3F);
        smp(1, 7'h3F, 1'b0); smp(1, 7'h3F);
        smp(1, 7'h3F, 1'b0);
        push(16'hA301, 4'h0, 1'b0); smp(1, 7'h3F);
        smp(1, 7'h3F);

        // Invalid blank pattern on digit 2 keeps nibble, sets error; valid clears it.
        smp(2, 7'h6D); smp(2, 7'h6D); push(16'hA501, 4'h0, 1'b0); smp(2, 7'h6D);
        smp(2, 7'h00); smp(2, 7'h00); push(16'hA501, 4'h4, 1'b0); smp(2, 7'h00);
        smp(2, 7'h4F); smp(2, 7'h4F); push(16'hA301, 4'h0, 1'b0); smp(2, 7'h4F);

        // Long hold on digit 3: one commit, completes the frame.
        smp(3, 7'h71); smp(3, 7'h71); push(16'hF301, 4'h0, 1'b1); smp(3, 7'h71);
        for (int i = 0; i < 7; i++) smp(3, 7'h71);

        // Out-of-range index interleaved with a run on the 3-digit instance.
        sel = 1'b1;
        smp(0, 7'h06); smp(3, 7'h06); smp(0, 7'h06); smp(3, 7'h06);
        push(16'h0001, 4'h0, 1'b0); smp(0, 7'h06);
        smp(3, 7'h06); smp(3, 7'h06);
        sel = 1'b0;

        // Clear mid-run with a concurrent sample.
        smp(1, 7'h66); smp(1, 7'h66);
        smp(1, 7'h66, 1'b1, 1'b1);
        chk_zero("midclear");
        smp(1, 7'h66); smp(1, 7'h66); push(16'h0040, 4'h0, 1'b0); smp(1, 7'h66);

        // Reset mid-run with a concurrent sample.
        smp(2, 7'h7D); smp(2, 7'h7D);
        smp(2, 7'h7D, 1'b1, 1'b0, 1'b1);
        chk_zero("midreset");
        smp(2, 7'h7D); smp(2, 7'h7D); push(16'h0600, 4'h0, 1'b0); smp(2, 7'h7D);

        smp(0, 7'h00, 1'b0);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg7_to_hex_capture.md
# seg7_to_hex_capture

Captures active-low 7-segment patterns from a scanned, multiplexed display bus and converts them back into hex nibbles. It is the decoder counterpart of the hex-to-7-segment encoding used on the DE1-SoC displays. Patterns pass through a stability filter before they are committed, and the result is assembled into a DIGITS-wide hex word. It sits between a display scan bus (driven by the design or sampled for self-check) and the checking or readback logic.

## Interface
- DIGITS, 4, number of display digits; value width is 4*DIGITS.
- STABLE_CNT, 3, consecutive identical valid samples required before a commit (range 1..255).
- IW, derived: max(1, ceil(log2(DIGITS))), width of dig_idx.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; sole reset.
- seg_n  in  7  segment pattern, active-low (0 = lit); bit0 = a … bit6 = g.
- dig_idx  in  IW  digit the pattern belongs to; indices >= DIGITS are ignored.
- seg_valid  in  1  sample strobe; seg_n/dig_idx are sampled only when it is high.
- clear  in  1  synchronous clear of captured state; lower priority than reset.
- value  out  4*DIGITS  decoded nibbles; digit k is value[4k+3:4k].
- digit_err  out  DIGITS  bit k is set when the last commit on digit k was an unrecognized pattern.
- commit  out  1  one-cycle pulse per commit.
- frame_done  out  1  one-cycle pulse when every digit has committed since the last frame_done, clear, or reset.

## Operation
- The decode table uses the active-high gfedcba view, p = ~seg_n:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=67, A=77, b=7C, c=58, d=5E, E=79, F=71
  - Any other p is invalid, including blank 00.
- The filter state is: cand_idx, cand_pat (7 bits), run count cnt (saturating at STABLE_CNT).
- Each sample with seg_valid=1 and dig_idx<DIGITS is processed as follows:
  - If dig_idx==cand_idx and seg_n==cand_pat and cnt≠0: cnt ← min(cnt+1, STABLE_CNT).
  - Otherwise: cand ← (dig_idx, seg_n) and cnt ← 1.
  - A commit fires on the sample where the new cnt first equals STABLE_CNT. Exactly one commit occurs per run, regardless of how long the run is held.
- Samples that do not affect the filter:
  - seg_valid=0 cycles leave the filter untouched, so gaps do not break a run.
  - An out-of-range dig_idx is dropped entirely; it does not reset cand.
- A commit on digit k does the following:
  - Valid pattern: nibble k ← decoded value and digit_err[k] ← 0.
  - Invalid pattern: nibble k is unchanged and digit_err[k] ← 1.
  - In both cases seen[k] ← 1, and commit pulses.
- Frame tracking, with seen_next = seen | (1<<k):
  - If seen_next is all ones: frame_done ← 1 and seen ← 0.
  - Otherwise: seen ← seen_next.
- clear=1:
  - Sets value=0, digit_err=0, seen=0, cnt=0, commit=0, frame_done=0.
  - A sample presented in the same cycle is discarded.
- reset=1: same effect as clear, and it overrides everything.
- Reset value of every output is 0: value, digit_err, commit, frame_done.

## Timing
- Commit latency is one cycle. Sampling edge N (the STABLE_CNT-th matching sample) produces value/digit_err updates, commit=1, and frame_done (if applicable), all visible after edge N. commit and frame_done drop after edge N+1 unless another commit fires.
- Back-to-back operation:
  - With STABLE_CNT=1, every accepted sample that starts a new run commits, so a commit is possible every cycle.
  - Repeated identical samples at STABLE_CNT=1 do not re-commit, because cnt is already saturated.
- The earliest frame for DIGITS distinct digits takes DIGITS*STABLE_CNT valid samples.
- A mid-run reset or clear discards the partial run; the next sample starts with cnt=1.
- The decode is combinational on cand or seg_n. All outputs are registered, with no combinational path from input to output.

## Test plan
- Reset, then three valid samples of digit 0 with seg_n=~7'h06: after the 3rd edge, value=16'h0001, one commit pulse, frame_done=0.
- Frame: digits 0,1,2,3 with patterns 06, 5B, 4F, 77, three samples each: value=16'hA321, four commit pulses, frame_done high only on the 4th commit, seen cleared afterwards.
- Glitch on digit 1: 8 (7F) ×2, 0 (3F) ×1, 0 ×3:
  - Exactly one commit, nibble 1 = 0.
  - The "8" run must not commit.
  - Insert seg_valid=0 gaps inside the final run; the result must be unchanged.
- Invalid input: seg_n=7'h7F (blank) ×3 on digit 2 after nibble 2 = 5:
  - digit_err=4'b0100 and nibble 2 stays 5.
  - A subsequent valid commit on digit 2 clears the bit.
- Hold and range: 10 identical samples produce exactly one commit. Out-of-range samples do not break a run (sequence: DIGITS=3, idx 3 between matching samples on idx 0).
- Clear/reset mid-run: after 2 of 3 samples, pulse clear together with a sample. All outputs are 0, the next 2 samples do not commit, and the 3rd does.
